// File: rtl/rob_completion_arbiter_if.sv
// rob_completion_arbiter_if
// Groups the execute-side completion handshake, the flush request and the
// ROB writeback ports of rob_completion_arbiter.
//   flush         : pipeline flush request
//   ex_*          : per-channel completion records (valid/ready handshake)
//   rob_wb_*      : registered ROB writeback ports
// Modports: slave = arbiter view, master = execute/ROB environment view.
interface rob_completion_arbiter_if #(
    parameter int NUM_EX   = 4,
    parameter int WB_PORTS = 2,
    parameter int IDXW     = 5,
    parameter int XLEN     = 32
) ();
    logic                               flush;
    logic [NUM_EX-1:0]                  ex_valid;
    logic [NUM_EX-1:0]                  ex_ready;
    logic [NUM_EX-1:0][IDXW-1:0]        ex_rob_idx;
    logic [NUM_EX-1:0]                  ex_br_mispred;
    logic [NUM_EX-1:0]                  ex_exception;
    logic [NUM_EX-1:0][XLEN-1:0]        ex_val;
    logic [WB_PORTS-1:0]                rob_wb_valid;
    logic [WB_PORTS-1:0][IDXW-1:0]      rob_wb_idx;
    logic [WB_PORTS-1:0]                rob_wb_br_mispred;
    logic [WB_PORTS-1:0]                rob_wb_exception;
    logic [WB_PORTS-1:0][XLEN-1:0]      rob_wb_val;

    modport slave (
        input  flush, ex_valid, ex_rob_idx, ex_br_mispred, ex_exception, ex_val,
        output ex_ready, rob_wb_valid, rob_wb_idx, rob_wb_br_mispred,
               rob_wb_exception, rob_wb_val
    );

    modport master (
        output flush, ex_valid, ex_rob_idx, ex_br_mispred, ex_exception, ex_val,
        input  ex_ready, rob_wb_valid, rob_wb_idx, rob_wb_br_mispred,
               rob_wb_exception, rob_wb_val
    );
endinterface

// File: rtl/rob_completion_arbiter.sv
// rob_completion_arbiter
// Buffers completion records from NUM_EX execute channels in per-channel
// circular queues and round-robin grants up to WB_PORTS queue heads per cycle
// onto registered ROB writeback ports. Flush discards everything in flight.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rob_completion_arbiter_if.slave (flush, ex_* in, rob_wb_* out)

// Per-channel completion queue.
module rob_cq_lane #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         ready,
    output logic         nonempty,
    output logic [W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks only at the registered count, never at a same-cycle pop.
    assign ready    = !rst && !flush && (count < CW'(DEPTH));
    assign nonempty = (count != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // push is already qualified by ready, so reset/flush never write.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module rob_completion_arbiter #(
    parameter int NUM_EX      = 4,
    parameter int WB_PORTS    = 2,
    parameter int CQ_DEPTH    = 2,
    parameter int ROB_ENTRIES = 32,
    parameter int XLEN        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    rob_completion_arbiter_if.slave  bus
);
    localparam int IDXW = $clog2(ROB_ENTRIES);
    localparam int RRW  = $clog2(NUM_EX);

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            br;
        logic            exc;
        logic [XLEN-1:0] val;
    } rec_t;

    rec_t [NUM_EX-1:0]   din, head;
    logic [NUM_EX-1:0]   push, grant, nonempty, ready;
    logic [RRW-1:0]      rr_ptr, next_rr;
    logic [WB_PORTS-1:0] port_hit, wb_valid;
    rec_t [WB_PORTS-1:0] port_rec, wb_rec;

    assign bus.ex_ready = ready;
    assign push         = bus.ex_valid & ready;

    for (genvar g = 0; g < NUM_EX; g++) begin : g_lane
        assign din[g] = {bus.ex_rob_idx[g], bus.ex_br_mispred[g],
                         bus.ex_exception[g], bus.ex_val[g]};
        rob_cq_lane #(.DEPTH(CQ_DEPTH), .W($bits(rec_t))) u_lane (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.flush),
            .push     (push[g]),
            .pop      (grant[g]),
            .din      (din[g]),
            .ready    (ready[g]),
            .nonempty (nonempty[g]),
            .head     (head[g])
        );
    end

    // Scan from rr_ptr; the k-th non-empty channel found feeds port k.
    always_comb begin
        int n;
        grant    = '0;
        port_hit = '0;
        port_rec = '0;
        next_rr  = rr_ptr;
        n        = 0;
        for (int j = 0; j < NUM_EX; j++) begin
            int ch;
            ch = int'(rr_ptr) + j;
            if (ch >= NUM_EX) ch = ch - NUM_EX;
            if (nonempty[ch] && n < WB_PORTS) begin
                grant[ch]   = 1'b1;
                port_hit[n] = 1'b1;
                port_rec[n] = head[ch];
                next_rr     = (ch == NUM_EX - 1) ? '0 : RRW'(ch + 1);
                n++;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            wb_valid <= '0;
            wb_rec   <= '0;
        end else if (bus.flush) begin
            rr_ptr   <= '0;
            wb_valid <= '0;
        end else begin
            rr_ptr   <= next_rr;
            wb_valid <= port_hit;
            for (int k = 0; k < WB_PORTS; k++)
                if (port_hit[k]) wb_rec[k] <= port_rec[k];
        end
    end

    assign bus.rob_wb_valid = wb_valid;
    for (genvar k = 0; k < WB_PORTS; k++) begin : g_port
        assign bus.rob_wb_idx[k]        = wb_rec[k].idx;
        assign bus.rob_wb_br_mispred[k] = wb_rec[k].br;
        assign bus.rob_wb_exception[k]  = wb_rec[k].exc;
        assign bus.rob_wb_val[k]        = wb_rec[k].val;
    end
endmodule

// File: tb/tb_rob_completion_arbiter.sv
// tb_rob_completion_arbiter
// Scoreboard bench: a queue-level reference model runs on each rising edge and
// pushes the writeback beats it expects (tagged with the cycle they must
// appear in); a monitor on the falling edge pops and compares them, and checks
// ex_ready against the model's queue occupancy.
module tb_rob_completion_arbiter;
    localparam int N  = 4;
    localparam int P  = 2;
    localparam int D  = 2;
    localparam int IW = 5;
    localparam int XL = 32;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          br;
        logic          exc;
        logic [XL-1:0] val;
    } rec_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] port;
        rec_t        r;
    } beat_t;

    logic clk, rst;
    rob_completion_arbiter_if #(.NUM_EX(N), .WB_PORTS(P), .IDXW(IW), .XLEN(XL)) bus ();

    rob_completion_arbiter #(
        .NUM_EX(N), .WB_PORTS(P), .CQ_DEPTH(D), .ROB_ENTRIES(32), .XLEN(XL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int mrr    = 0;
    rec_t  mq [N][$];
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Reference model: queues per channel, rotating start channel.
    always @(posedge clk) begin
        logic [N-1:0] mrdy;
        int n, ch, last;
        cyc++;
        if (rst || bus.flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mrr = 0;
        end else begin
            for (int i = 0; i < N; i++) mrdy[i] = (mq[i].size() < D);
            n = 0;
            last = 0;
            for (int j = 0; j < N; j++) begin
                ch = (mrr + j) % N;
                if (mq[ch].size() > 0 && n < P) begin
                    beat_t b;
                    b.cyc  = cyc;
                    b.port = n;
                    b.r    = mq[ch].pop_front();
                    exp_q.push_back(b);
                    last = ch;
                    n++;
                end
            end
            if (n > 0) mrr = (last + 1) % N;
            for (int i = 0; i < N; i++)
                if (bus.ex_valid[i] && mrdy[i]) begin
                    rec_t r;
                    r.idx = bus.ex_rob_idx[i];
                    r.br  = bus.ex_br_mispred[i];
                    r.exc = bus.ex_exception[i];
                    r.val = bus.ex_val[i];
                    mq[i].push_back(r);
                end
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [N-1:0] erdy;
        for (int i = 0; i < N; i++) erdy[i] = !rst && !bus.flush && (mq[i].size() < D);
        chk("ex_ready", 64'(bus.ex_ready), 64'(erdy));
        if (rst) begin
            chk("wb_valid_in_rst", 64'(bus.rob_wb_valid), 64'(0));
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) void'(exp_q.pop_front());
        end else begin
            for (int k = 0; k < P; k++) begin
                if (bus.rob_wb_valid[k]) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].port != k) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_wb port %0d @cyc %0d: got idx %0h, none expected",
                                 k, cyc, bus.rob_wb_idx[k]);
                    end else begin
                        beat_t b;
                        rec_t  a;
                        b = exp_q.pop_front();
                        a.idx = bus.rob_wb_idx[k];
                        a.br  = bus.rob_wb_br_mispred[k];
                        a.exc = bus.rob_wb_exception[k];
                        a.val = bus.rob_wb_val[k];
                        chk("wb_record", 64'(a), 64'(b.r));
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                checks++;
                fails++;
                $display("FAIL missing_wb port %0d @cyc %0d: got no beat, expected idx %0h",
                         exp_q[0].port, cyc, exp_q[0].r.idx);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid      = '0;
        bus.ex_br_mispred = '0;
        bus.ex_exception  = '0;
        bus.flush         = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.ex_valid = '1;
        bus.ex_rob_idx = '0;
        bus.ex_br_mispred = '0;
        bus.ex_exception = '0;
        bus.ex_val = '0;

        // Reset with all channels offering
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_ready", 64'(bus.ex_ready), 64'(0));
        chk("rst_wb_valid", 64'(bus.rob_wb_valid), 64'(0));
        chk("rst_wb_idx", 64'(bus.rob_wb_idx), 64'(0));
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.ex_ready), 64'hF);

        // Single completion on channel 2
        step();
        bus.ex_valid = 4'b0100;
        bus.ex_rob_idx[2] = 5'd5;
        bus.ex_val[2] = 32'hDEADBEEF;
        step();
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("single_valid", 64'(bus.rob_wb_valid), 64'b01);
        chk("single_idx", 64'(bus.rob_wb_idx[0]), 64'd5);
        chk("single_val", 64'(bus.rob_wb_val[0]), 64'hDEADBEEF);

        // Flush returns the round-robin start to channel 0, then contention
        step();
        bus.flush = 1'b1;
        step();
        idle();
        bus.ex_valid = 4'b1111;
        for (int i = 0; i < N; i++) bus.ex_rob_idx[i] = IW'(10 + i);
        step();
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("cont_valid0", 64'(bus.rob_wb_valid), 64'b11);
        chk("cont_idx0", 64'({bus.rob_wb_idx[1], bus.rob_wb_idx[0]}), 64'({5'd11, 5'd10}));
        @(negedge clk);
        chk("cont_valid1", 64'(bus.rob_wb_valid), 64'b11);
        chk("cont_idx1", 64'({bus.rob_wb_idx[1], bus.rob_wb_idx[0]}), 64'({5'd13, 5'd12}));

        // Flags ride through unchanged
        step();
        bus.ex_valid = 4'b0110;
        bus.ex_rob_idx[1] = 5'd9;
        bus.ex_exception[1] = 1'b1;
        bus.ex_rob_idx[2] = 5'd10;
        bus.ex_br_mispred[2] = 1'b1;
        step();
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("flag_idx", 64'({bus.rob_wb_idx[1], bus.rob_wb_idx[0]}), 64'({5'd10, 5'd9}));
        chk("flag_exc", 64'(bus.rob_wb_exception), 64'b01);
        chk("flag_br", 64'(bus.rob_wb_br_mispred), 64'b10);

        // Flush with ch0/ch3 holding records
        step();
        bus.ex_valid = 4'b1001;
        step();
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 64'(bus.ex_ready), 64'h0);
        step();
        idle();
        @(negedge clk);
        chk("flush_wb_none", 64'(bus.rob_wb_valid), 64'b00);
        chk("flush_ready_back", 64'(bus.ex_ready), 64'hF);
        @(negedge clk);
        chk("flush_wb_none2", 64'(bus.rob_wb_valid), 64'b00);
        step();
        bus.ex_valid = 4'b0001;
        bus.ex_rob_idx[0] = 5'd7;
        step();
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("post_flush_valid", 64'(bus.rob_wb_valid), 64'b01);
        chk("post_flush_idx", 64'(bus.rob_wb_idx[0]), 64'd7);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.ex_valid      = N'($urandom);
            bus.ex_br_mispred = N'($urandom);
            bus.ex_exception  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.ex_rob_idx[i] = IW'($urandom);
                bus.ex_val[i]     = $urandom;
            end
            bus.flush = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) == 0);
        end
        step();
        rst = 1'b0;
        idle();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
